mem_arbiter: RTL

Sits between the instruction cache refill path, the load/store buffer and the single request port of the byte-serial memory controller, time-sharing that port. Converts an icache miss into a LINE_WORDS-word burst of word reads, forwards LSB loads/stores unchanged, alternates grants fairly, and handles rollback without corrupting an in-flight controller transaction. All controller-side fields are registered and held stable for the whole transaction.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Time-shares the single memory-controller request port between icache line
// refills (split into word reads) and load/store-buffer accesses.
module mem_arbiter #(
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             io_buffer_full,
   // icache refill side
   input  logic             ic_req,
   input  logic [31:0]      ic_addr,
   output logic             ic_word_valid,
   output logic [IDX_W-1:0] ic_word_idx,
   output logic [31:0]      ic_word,
   output logic             ic_done,
   // load/store buffer side
   input  logic             lsb_req,
   input  logic             lsb_wr,
   input  logic [31:0]      lsb_addr,
   input  logic [2:0]       lsb_type,
   input  logic [31:0]      lsb_st_val,
   output logic             lsb_done,
   output logic [31:0]      lsb_ld_val,
   // memory controller side
   output logic             mc_enable,
   output logic             mc_wr,
   output logic [31:0]      mc_addr,
   output logic [2:0]       mc_type,
   output logic [31:0]      mc_st_val,
   input  logic             mc_done,
   input  logic [31:0]      mc_result
);

   typedef enum logic [2:0] {IDLE, IF_BUSY, LS_BUSY, DRAIN, GAP} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
   localparam logic [2:0]       TYPE_LW  = 3'b010;

   state_t           state, state_nxt;
   logic             last_ls;      // 1: the LSB won the most recent grant
   logic [IDX_W-1:0] cnt;
   logic [31:0]      line_base;

   logic lsb_ok, done_seen;
   logic grant_if, grant_ls, reissue, drop, word_ok, ls_ok;

   // A store to the UART window must wait while its buffer is full.
   assign lsb_ok    = lsb_req && !(lsb_wr && lsb_addr[17:16] == 2'b11 && io_buffer_full);
   assign done_seen = mc_enable && mc_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else if (rdy)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_ls  = 1'b0;
      reissue   = 1'b0;
      drop      = 1'b0;
      word_ok   = 1'b0;
      ls_ok     = 1'b0;
      case (state)
         IDLE: begin
            if (!rollback) begin
               if (ic_req && lsb_ok) begin
                  grant_if = last_ls;
                  grant_ls = !last_ls;
               end else begin
                  grant_if = ic_req;
                  grant_ls = lsb_ok;
               end
            end
            if (grant_if)      state_nxt = IF_BUSY;
            else if (grant_ls) state_nxt = LS_BUSY;
         end
         IF_BUSY: begin
            if (!mc_enable) begin
               // Between words nothing is in flight, so rollback can leave now.
               if (rollback) state_nxt = GAP;
               else          reissue   = 1'b1;
            end else if (mc_done) begin
               drop = 1'b1;
               if (rollback) begin
                  state_nxt = GAP;
               end else begin
                  word_ok = 1'b1;
                  if (cnt == LAST_IDX) state_nxt = GAP;
               end
            end else if (rollback) begin
               state_nxt = DRAIN;
            end
         end
         LS_BUSY: begin
            if (done_seen) begin
               drop      = 1'b1;
               ls_ok     = mc_wr || !rollback;
               state_nxt = GAP;
            end else if (rollback && !mc_wr) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (done_seen) begin
               drop      = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_ls       <= 1'b0;
         cnt           <= '0;
         line_base     <= '0;
         ic_word_valid <= 1'b0;
         ic_word_idx   <= '0;
         ic_word       <= '0;
         ic_done       <= 1'b0;
         lsb_done      <= 1'b0;
         lsb_ld_val    <= '0;
         mc_enable     <= 1'b0;
         mc_wr         <= 1'b0;
         mc_addr       <= '0;
         mc_type       <= '0;
         mc_st_val     <= '0;
      end else if (rdy) begin
         ic_word_valid <= 1'b0;
         ic_done       <= 1'b0;
         lsb_done      <= 1'b0;
         if (grant_if) begin
            last_ls   <= 1'b0;
            line_base <= ic_addr;
            cnt       <= '0;
            mc_enable <= 1'b1;
            mc_wr     <= 1'b0;
            mc_addr   <= ic_addr;
            mc_type   <= TYPE_LW;
            mc_st_val <= '0;
         end
         if (grant_ls) begin
            last_ls   <= 1'b1;
            mc_enable <= 1'b1;
            mc_wr     <= lsb_wr;
            mc_addr   <= lsb_addr;
            mc_type   <= lsb_type;
            mc_st_val <= lsb_st_val;
         end
         if (reissue) begin
            mc_enable <= 1'b1;
            mc_addr   <= line_base + {{(30-IDX_W){1'b0}}, cnt, 2'b00};
         end
         if (drop)
            mc_enable <= 1'b0;
         if (word_ok) begin
            ic_word_valid <= 1'b1;
            ic_word       <= mc_result;
            ic_word_idx   <= cnt;
            if (cnt == LAST_IDX) ic_done <= 1'b1;
            else                 cnt     <= cnt + 1'b1;
         end
         if (ls_ok) begin
            lsb_done <= 1'b1;
            if (!mc_wr) lsb_ld_val <= mc_result;
         end
      end
   end

endmodule
